// File: rtl/transmitter_txd.sv
// transmitter_txd: UART 8N1 transmitter with a one-entry holding register.
//   Each frame is a start bit, 8 data bits LSB first, and a stop bit. Each bit
//   lasts CLKS_PER_BIT clocks. A byte queued in the holding register during a
//   frame is loaded on the edge that ends the stop bit, so the next frame
//   follows with no idle gap.
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active high
//   tx_valid  byte offered on tx_data this cycle
//   tx_data   byte to send, captured when tx_valid && tx_ready
//   tx_ready  holding register empty
//   TxD       registered serial line, idle high
//   tx_busy   a frame is shifting or a byte is held
//   tx_done   one-cycle pulse in the first cycle after each stop bit
module transmitter_txd #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       TxD,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift_reg, shift_n;
  logic [7:0]    hold_data;
  logic          hold_full;
  logic          txd_q, txd_n;
  logic          done_q, done_n;
  logic          load, accept, bit_end;

  assign accept   = tx_valid && !hold_full;
  assign bit_end  = (bit_cnt == LAST);
  assign tx_ready = !hold_full;
  assign tx_busy  = (state != IDLE) || hold_full;
  assign TxD      = txd_q;
  assign tx_done  = done_q;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_end ? '0 : bit_cnt + 1'b1;
    idx_n     = idx;
    load      = 1'b0;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        bit_cnt_n = '0;
        if (hold_full) begin
          load    = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          idx_n   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          done_n = 1'b1;
          // A held byte starts its start bit on the same edge, no idle cycle.
          if (hold_full) begin
            load    = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    shift_n = load ? hold_data : shift_reg;
    // The line is registered: decode it from next-state values so TxD
    // changes on the same edge as the state.
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[idx_n];
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      idx       <= 3'd0;
      shift_reg <= 8'h00;
      hold_data <= 8'h00;
      hold_full <= 1'b0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      idx       <= idx_n;
      shift_reg <= shift_n;
      txd_q     <= txd_n;
      done_q    <= done_n;
      // accept requires !hold_full and load requires hold_full: never both.
      if (load)        hold_full <= 1'b0;
      else if (accept) hold_full <= 1'b1;
      if (accept) hold_data <= tx_data;
    end
  end

endmodule

// File: tb/tb_transmitter_txd.sv
module tb_transmitter_txd;
  localparam int CPB = 4;
  localparam int NS  = 90;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, TxD, tx_busy, tx_done;

  int checks = 0;
  int failures = 0;

  transmitter_txd #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .TxD(TxD), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [3:0] exp;   // {TxD, tx_ready, tx_busy, tx_done}
  } vec_t;

  vec_t vecs[$];
  logic ws[NS];
  logic ds[NS];
  logic rs[NS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic v, input logic [7:0] d, input logic [3:0] e);
    vec_t t;
    t.valid = v; t.data = d; t.exp = e;
    vecs.push_back(t);
  endfunction

  // Per-clock expectation for one frame sent from idle: acceptance edge,
  // 40 line clocks, then the tx_done cycle.
  function automatic void add_frame(input logic [7:0] d);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    push(1'b1, d, 4'b1010);
    for (int j = 0; j < 10 * CPB; j++)
      push(1'b0, 8'h00, {fr[j / CPB], 1'b1, 1'b1, 1'b0});
    push(1'b0, 8'h00, 4'b1101);
  endfunction

  // Samples the line each clock starting one edge after acceptance of first.
  // Optional second offer at sample a_at, and a junk offer over [b_lo,b_hi].
  task automatic capture(input logic [7:0] first, input int a_at, input logic [7:0] a_dat,
                         input int b_lo, input int b_hi, input logic [7:0] b_dat);
    tx_valid = 1'b1; tx_data = first;
    step();
    for (int i = 0; i < NS; i++) begin
      tx_valid = 1'b0; tx_data = 8'h00;
      if (i == a_at) begin tx_valid = 1'b1; tx_data = a_dat; end
      else if (i >= b_lo && i <= b_hi) begin tx_valid = 1'b1; tx_data = b_dat; end
      rs[i] = tx_ready;
      step();
      ws[i] = TxD;
      ds[i] = tx_done;
    end
    tx_valid = 1'b0;
  endtask

  function automatic logic [9:0] frame_at(input int base);
    logic [9:0] f;
    for (int b = 0; b < 10; b++) f[b] = ws[base + b * CPB + CPB / 2];
    return f;
  endfunction

  function automatic int done_count();
    int n = 0;
    for (int i = 0; i < NS; i++) if (ds[i]) n++;
    return n;
  endfunction

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    step();
    step();
    chk("reset_state", {TxD, tx_ready, tx_busy, tx_done}, 4'b1100);
    reset = 1'b0;
    step();
    chk("idle_after_reset", {TxD, tx_ready, tx_busy, tx_done}, 4'b1100);

    // Exact per-clock waveforms for the edge values.
    add_frame(8'h00);
    add_frame(8'hFF);
    add_frame(8'hAA);
    for (int v = 0; v < vecs.size(); v++) begin
      tx_valid = vecs[v].valid;
      tx_data  = vecs[v].data;
      step();
      chk($sformatf("vec%0d", v), {TxD, tx_ready, tx_busy, tx_done}, vecs[v].exp);
    end
    tx_valid = 1'b0;
    step();

    // Back-to-back: second byte offered during the first frame's data bits.
    capture(8'h55, 12, 8'hA5, -1, -1, 8'h00);
    chk("b2b_ready_at_offer", rs[12], 1);
    chk("b2b_frame1", frame_at(0), {1'b1, 8'h55, 1'b0});
    chk("b2b_frame2", frame_at(40), {1'b1, 8'hA5, 1'b0});
    chk("b2b_no_gap", {ws[39], ws[40]}, 2'b10);
    chk("b2b_done1", ds[40], 1);
    chk("b2b_done2", ds[80], 1);
    chk("b2b_done_count", done_count(), 2);
    chk("b2b_idle_after", {TxD, tx_ready, tx_busy, tx_done}, 4'b1100);

    // 0x22 queued, then 0x11 offered while full: 0x11 must be dropped.
    capture(8'h33, 5, 8'h22, 10, 35, 8'h11);
    chk("drop_ready_low", rs[10], 0);
    chk("drop_frame1", frame_at(0), {1'b1, 8'h33, 1'b0});
    chk("drop_frame2", frame_at(40), {1'b1, 8'h22, 1'b0});
    chk("drop_done_count", done_count(), 2);
    chk("drop_idle_after", {TxD, tx_ready, tx_busy, tx_done}, 4'b1100);

    // Reset during data bit 3 of 0x0F.
    tx_valid = 1'b1; tx_data = 8'h0F;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 18; i++) step();
    chk("abort_pre_bit3", {TxD, tx_busy}, 2'b11);
    reset = 1'b1;
    step();
    chk("abort_reset_edge", {TxD, tx_ready, tx_busy, tx_done}, 4'b1100);
    reset = 1'b0;
    begin
      int bad = 0;
      for (int i = 0; i < 60; i++) begin
        step();
        if ({TxD, tx_ready, tx_busy, tx_done} !== 4'b1100) bad++;
      end
      chk("abort_not_resumed", bad, 0);
    end
    capture(8'hF0, -1, 8'h00, -1, -1, 8'h00);
    chk("after_abort_frame", frame_at(0), {1'b1, 8'hF0, 1'b0});
    chk("after_abort_done", ds[40], 1);
    chk("after_abort_count", done_count(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/transmitter_txd.md
# transmitter_txd

UART transmitter sending 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) on a serial line at a fixed bit period of CLKS_PER_BIT clocks (default 5208 clocks = 9600 baud at 50 MHz). It drives the line sampled by receiver_RxD in the UART module. A one-entry holding register lets the next byte be queued while the current frame is shifting, so back-to-back frames go out with no idle gap.

## Interface
- CLKS_PER_BIT, 5208: clocks per serial bit; legal range ≥ 2. The bit counter is $clog2(CLKS_PER_BIT) bits wide.
- clk  input  1  system clock, 50 MHz, rising-edge.
- reset  input  1  synchronous, active-high.
- tx_valid  input  1  byte on tx_data offered this cycle.
- tx_data  input  8  byte to send; sampled only on acceptance.
- tx_ready  output  1  holding register empty; a byte is accepted when tx_valid && tx_ready at a rising edge.
- TxD  output  1  serial line, registered, idle high.
- tx_busy  output  1  high while a frame is shifting or a byte is held.
- tx_done  output  1  one-cycle pulse at the end of each frame's stop bit.

## Operation
- Holding register hold_data[7:0] with flag hold_full. Acceptance sets hold_full and captures tx_data. tx_ready = !hold_full.
- Shifter FSM states: IDLE, START, DATA, STOP. Baud counter bit_cnt counts 0..CLKS_PER_BIT-1. Bit index idx is 0..7.
- IDLE: TxD=1. If hold_full, then on the next edge: load shift_reg from hold_data, clear hold_full, bit_cnt=0, go to START.
- START: TxD=0 for CLKS_PER_BIT cycles, then DATA with idx=0.
- DATA: TxD=shift_reg[idx] for CLKS_PER_BIT cycles per bit. After idx=7 finishes, go to STOP.
- STOP: TxD=1 for CLKS_PER_BIT cycles. On the final-cycle edge, tx_done pulses. If hold_full, load from hold and go directly to START (no idle cycle). Otherwise go to IDLE.
- Because acceptance needs !hold_full and loading clears hold_full, acceptance and load never fall in the same edge. tx_ready rises the cycle after the load.
- tx_valid while tx_ready=0 is ignored: no capture, and the held byte is not overwritten.
- tx_busy = (state != IDLE) || hold_full.
- Reset, including mid-frame: state=IDLE, hold_full=0, bit_cnt=0, idx=0. Outputs: TxD=1, tx_ready=1, tx_busy=0, tx_done=0. An aborted frame is not resumed.

## Timing
- Byte accepted at edge k with FSM IDLE: hold_full=1 after k. Load occurs at edge k+1, so TxD=0 from edge k+1. Latency is 1 clock from acceptance to start bit.
- Each bit lasts exactly CLKS_PER_BIT clocks. A frame lasts 10·CLKS_PER_BIT clocks (52080 at default), from TxD falling to the end of the stop bit.
- tx_done is high for exactly one cycle. It coincides with the first cycle after the stop bit: TxD is high (idle) or low (next start bit).
- Back-to-back: if hold_full at the end of the stop bit, the next start bit begins on the same edge that ends the stop bit.
- tx_ready low from acceptance until the edge after the load. The minimum hold occupancy is 1 clock when the FSM is IDLE.

## Test plan
- Single 0xAA after reset, sampling TxD at 2604 clocks into each bit → 0,0,1,0,1,0,1,0,1,1. TxD falls 1 clock after acceptance. tx_done pulses 52080 clocks after the fall. tx_busy then drops.
- Back-to-back 0x55 then 0xA5, second queued during the first frame's DATA → the second start bit begins exactly at the end of the first stop bit, with no high gap beyond one bit time. Bits decode 0x55 then 0xA5. tx_done pulses twice.
- tx_valid held with 0x11 while tx_ready=0 (hold already holds 0x22) → 0x11 is dropped. The frames sent are the current one and then 0x22.
- Reset asserted during DATA bit 3 of 0x0F → the next edge shows TxD=1, tx_ready=1, tx_busy=0, and no tx_done. A new 0xF0 afterwards is sent correctly.
- Edge values 0x00 and 0xFF, CLKS_PER_BIT=4 → exact per-clock TxD waveform. Each frame is 40 clocks long.
- Loopback into receiver_RxD at the default CLKS_PER_BIT, sending 0x3C → RxData=0x3C after the frame completes.
